adder_operand_dispatcher: RTL
=============================

# adder_operand_dispatcher

Clocked initiator that drives the select-adder channel protocol: accepts one command (select, operand A, operand B) from upstream, issues the select and B tokens in parallel, then issues A on the lane chosen by the select, collects the sum token, and returns it upstream. It sits between the synchronous SNN control logic and the selectable adder stage. It is the transmitter/collector counterpart of that adder and keeps exactly one transaction in flight.

## Interface
- WIDTH, 8, operand and sum width
- CNT_W, 16, width of transaction counter
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  upstream command present
- cmd_ready  out  1  dispatcher can accept command
- cmd_sel  in  2  select; 0 -> lane a_0, 1..3 -> lane a_1
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B
- sel_valid / sel_ready  out / in  1 / 1  select channel handshake
- sel_data  out  2  select token
- b_valid / b_ready  out / in  1 / 1  B channel handshake
- b_data  out  WIDTH  B token
- a0_valid / a0_ready  out / in  1 / 1  lane-0 A channel
- a1_valid / a1_ready  out / in  1 / 1  lane-1 A channel
- a_data  out  WIDTH  A token, shared by both lanes
- sum_valid / sum_ready  in / out  1 / 1  sum channel from adder
- sum_data  in  WIDTH  sum token
- rsp_valid / rsp_ready  out / in  1 / 1  upstream response handshake
- rsp_data  out  WIDTH  returned sum
- txn_count  out  CNT_W  completed transactions
- err_mismatch  out  1  sticky sum-check error

## Operation
- Handshake on any channel: transfer when valid & ready on a rising edge; valid, once high, holds with stable data until transfer.
- FSM states: IDLE, SEND_SB, SEND_A, WAIT_SUM, RESP.
- IDLE: cmd_ready=1. On cmd transfer, latch sel/a/b, go SEND_SB.
- SEND_SB: sel_valid and b_valid asserted together; each drops the cycle after its own transfer; both may transfer in the same or different cycles, in either order. Leave when both done.
- SEND_A: exactly one of a0_valid (latched sel==0) or a1_valid (sel!=0); other lane stays 0. On transfer go WAIT_SUM.
- WAIT_SUM: sum_ready=1; on transfer latch sum_data, go RESP. sum_ready=0 in all other states; a sum_valid outside WAIT_SUM is ignored and not consumed.
- RESP: rsp_valid=1, rsp_data=latched sum; on transfer increment txn_count (wraps 2^CNT_W-1 -> 0), go IDLE.
- Sum arithmetic: WIDTH bits, modulo 2^WIDTH, no carry out.
- Reset (any state, including mid-transaction): state IDLE; all valid outputs, sum_ready, txn_count, err_mismatch, and all data registers 0; cmd_ready 1 after reset deasserts. In-flight transaction is dropped.

## Timing
- Cmd accepted at edge N -> sel_valid/b_valid high from cycle N+1.
- With all downstream readies held high: sel/b transfer at N+1, A at N+2, sum at N+3 earliest, rsp_valid at N+4, rsp transfer at N+4, cmd_ready again at N+5. Minimum issue interval: 5 cycles.
- Outputs registered; no combinational path input -> output except none: cmd_ready and sum_ready decode from state only.
- A is never offered before both sel and B have transferred.

## Configuration
- ADDER_DISP_CHECK_EN defined: expected = latched a + latched b (mod 2^WIDTH) compared with sum_data on sum transfer; mismatch sets err_mismatch, cleared only by reset.
- Not defined: no comparator; err_mismatch tied 0.

## Structure
- Package adder_disp_pkg: state enum disp_state_t, SEL_W=2 constant, lane-select decode function (sel != 0 -> lane 1).
- Sub-module adder_disp_chan_tx: one-slot valid/ready source (load, hold, clear on transfer), instantiated for select, B, and A channels.

## Test plan
- All readies high, cmd sel=0 a=8'h12 b=8'h34, adder returns 8'h46 -> a0_valid only, rsp_data 8'h46 at cycle N+4, txn_count 1.
- sel=2 a=8'hF0 b=8'h20, sum 8'h10 -> a1_valid only, a0_valid stays 0, rsp_data 8'h10 (wrap).
- b_ready delayed 3 cycles after sel_ready -> sel_valid drops after its transfer, b_valid holds; no A valid until B transfers.
- Reset asserted in WAIT_SUM -> next cycle all valids 0, cmd_ready 1, txn_count 0; late sum_valid not consumed.
- With ADDER_DISP_CHECK_EN, a=1 b=1, adder returns 3 -> err_mismatch 1 and stays 1 across next good transaction.
- rsp_ready held low 4 cycles -> rsp_valid/rsp_data stable, cmd_ready 0 throughout.

Source files
------------

// File: rtl/adder_operand_dispatcher_pkg.sv
// Shared types and helpers for the select-adder operand dispatcher.
// Holds the FSM state encoding, select width and lane decode.
package adder_disp_pkg;

  localparam int SEL_W = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_SB  = 3'd1,
    SEND_A   = 3'd2,
    WAIT_SUM = 3'd3,
    RESP     = 3'd4
  } disp_state_t;

  // Select 0 routes operand A to lane 0; any other select uses lane 1.
  function automatic logic lane_of(input logic [SEL_W-1:0] sel);
    return (sel != {SEL_W{1'b0}});
  endfunction

endpackage

// File: rtl/adder_operand_dispatcher_if.sv
// Handshake bundle between the dispatcher, its upstream command source
// and the selectable adder stage. master = dispatcher side.
interface adder_disp_if #(
  parameter int WIDTH = 8
);

  logic                             cmd_valid;
  logic                             cmd_ready;
  logic [adder_disp_pkg::SEL_W-1:0] cmd_sel;
  logic [WIDTH-1:0]                 cmd_a;
  logic [WIDTH-1:0]                 cmd_b;

  logic                             sel_valid;
  logic                             sel_ready;
  logic [adder_disp_pkg::SEL_W-1:0] sel_data;

  logic                             b_valid;
  logic                             b_ready;
  logic [WIDTH-1:0]                 b_data;

  logic                             a0_valid;
  logic                             a0_ready;
  logic                             a1_valid;
  logic                             a1_ready;
  logic [WIDTH-1:0]                 a_data;

  logic                             sum_valid;
  logic                             sum_ready;
  logic [WIDTH-1:0]                 sum_data;

  logic                             rsp_valid;
  logic                             rsp_ready;
  logic [WIDTH-1:0]                 rsp_data;

  modport master (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b,
    output cmd_ready,
    output sel_valid, sel_data,
    input  sel_ready,
    output b_valid, b_data,
    input  b_ready,
    output a0_valid, a1_valid, a_data,
    input  a0_ready, a1_ready,
    input  sum_valid, sum_data,
    output sum_ready,
    output rsp_valid, rsp_data,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_sel, cmd_a, cmd_b,
    input  cmd_ready,
    input  sel_valid, sel_data,
    output sel_ready,
    input  b_valid, b_data,
    output b_ready,
    input  a0_valid, a1_valid, a_data,
    output a0_ready, a1_ready,
    output sum_valid, sum_data,
    input  sum_ready,
    input  rsp_valid, rsp_data,
    output rsp_ready
  );

endinterface

// File: rtl/adder_operand_dispatcher_chan_tx.sv
// One-slot valid/ready source: load captures a token, valid holds with
// stable data until the transfer edge, then drops.
module adder_disp_chan_tx #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_r;
  logic [W-1:0] data_r;

  // Slot register: load wins, otherwise clear on transfer, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= {W{1'b0}};
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
    end else if (valid_r && ready) begin
      valid_r <= 1'b0;
      data_r  <= data_r;
    end else begin
      valid_r <= valid_r;
      data_r  <= data_r;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/adder_operand_dispatcher.sv
// Single-transaction initiator for the select-adder channel protocol.
// Optional sum checker enabled by defining ADDER_DISP_CHECK_EN.
module adder_operand_dispatcher
  import adder_disp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  adder_disp_if.master     bus,
  output logic [CNT_W-1:0] txn_count,
  output logic             err_mismatch
);

  disp_state_t      state_r;
  logic [SEL_W-1:0] sel_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             lane_r;
  logic             rsp_valid_r;
  logic [CNT_W-1:0] txn_count_r;

  logic             cmd_fire_s;
  logic             sb_done_s;
  logic             a_fire_s;
  logic             sum_fire_s;
  logic             rsp_fire_s;
  logic             a_ready_s;
  logic             sel_valid_s;
  logic             b_valid_s;
  logic             a_valid_s;
  logic [SEL_W-1:0] sel_data_s;
  logic [WIDTH-1:0] b_data_s;
  logic [WIDTH-1:0] a_data_s;

  assign cmd_fire_s = (state_r == IDLE) && bus.cmd_valid;
  // A is loaded only once both select and B have left (or leave this edge).
  assign sb_done_s  = (state_r == SEND_SB) &&
                      (!sel_valid_s || bus.sel_ready) &&
                      (!b_valid_s || bus.b_ready);
  assign a_ready_s  = lane_r ? bus.a1_ready : bus.a0_ready;
  assign a_fire_s   = a_valid_s && a_ready_s;
  assign sum_fire_s = (state_r == WAIT_SUM) && bus.sum_valid;
  assign rsp_fire_s = rsp_valid_r && bus.rsp_ready;

  adder_disp_chan_tx #(.W(SEL_W)) u_sel_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cmd_fire_s),
    .load_data (bus.cmd_sel),
    .ready     (bus.sel_ready),
    .valid     (sel_valid_s),
    .data      (sel_data_s)
  );

  adder_disp_chan_tx #(.W(WIDTH)) u_b_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cmd_fire_s),
    .load_data (bus.cmd_b),
    .ready     (bus.b_ready),
    .valid     (b_valid_s),
    .data      (b_data_s)
  );

  adder_disp_chan_tx #(.W(WIDTH)) u_a_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sb_done_s),
    .load_data (a_r),
    .ready     (a_ready_s),
    .valid     (a_valid_s),
    .data      (a_data_s)
  );

  // Transaction sequencer: latches the command, tracks phases, holds the response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      sel_r       <= {SEL_W{1'b0}};
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      lane_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      txn_count_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_fire_s) begin
            sel_r   <= bus.cmd_sel;
            a_r     <= bus.cmd_a;
            b_r     <= bus.cmd_b;
            lane_r  <= lane_of(bus.cmd_sel);
            state_r <= SEND_SB;
          end else begin
            state_r <= IDLE;
          end
        end
        SEND_SB: begin
          if (sb_done_s) begin
            state_r <= SEND_A;
          end else begin
            state_r <= SEND_SB;
          end
        end
        SEND_A: begin
          if (a_fire_s) begin
            state_r <= WAIT_SUM;
          end else begin
            state_r <= SEND_A;
          end
        end
        WAIT_SUM: begin
          if (sum_fire_s) begin
            sum_r       <= bus.sum_data;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end else begin
            state_r <= WAIT_SUM;
          end
        end
        RESP: begin
          if (rsp_fire_s) begin
            rsp_valid_r <= 1'b0;
            txn_count_r <= txn_count_r + CNT_W'(1);
            state_r     <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

`ifdef ADDER_DISP_CHECK_EN
  logic [WIDTH-1:0] exp_sum_s;
  logic             err_r;

  assign exp_sum_s = a_r + b_r;

  // Sticky flag: any returned sum that differs from a + b (mod 2^WIDTH).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (sum_fire_s && (bus.sum_data != exp_sum_s)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err_mismatch = err_r;
`else
  assign err_mismatch = 1'b0;
`endif

  assign bus.cmd_ready = (state_r == IDLE);
  assign bus.sum_ready = (state_r == WAIT_SUM);
  assign bus.sel_valid = sel_valid_s;
  assign bus.sel_data  = sel_data_s;
  assign bus.b_valid   = b_valid_s;
  assign bus.b_data    = b_data_s;
  assign bus.a0_valid  = a_valid_s && !lane_r;
  assign bus.a1_valid  = a_valid_s && lane_r;
  assign bus.a_data    = a_data_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = sum_r;
  assign txn_count     = txn_count_r;

endmodule
